// File: rtl/tick_bcd_stopwatch.sv
// MM:SS BCD stopwatch advanced by a 1 Hz tick, with start/stop and clear buttons.
// Optional lap-hold display freeze is compiled in when LAP_HOLD_EN is defined.
module tick_bcd_stopwatch #(
   parameter int MAX_MINUTES = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       wrap,
   output logic       lap_held
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [3:0] MAX_TENS = 4'(MAX_MINUTES / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_MINUTES % 10);

   state_t     state;
   logic [3:0] s1, s10, m1, m10;
   logic       ss_hist, clr_hist;
   logic       ss_ev, clr_ev, at_max;

   assign ss_ev   = start_stop & ~ss_hist;
   assign clr_ev  = clear & ~clr_hist;
   assign at_max  = (m10 == MAX_TENS) && (m1 == MAX_ONES) && (s10 == 4'd5) && (s1 == 4'd9);
   assign running = (state == RUN);

   // Counting uses the pre-transition state, so a stop coinciding with a tick still counts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         s1       <= 4'd0;
         s10      <= 4'd0;
         m1       <= 4'd0;
         m10      <= 4'd0;
         wrap     <= 1'b0;
         ss_hist  <= 1'b1;
         clr_hist <= 1'b1;
      end else begin
         ss_hist  <= start_stop;
         clr_hist <= clear;
         wrap     <= 1'b0;
         if (clr_ev) begin
            state <= IDLE;
            s1    <= 4'd0;
            s10   <= 4'd0;
            m1    <= 4'd0;
            m10   <= 4'd0;
         end else begin
            if (state == RUN && tick) begin
               if (s1 != 4'd9) begin
                  s1 <= s1 + 4'd1;
               end else begin
                  s1 <= 4'd0;
                  if (s10 != 4'd5) begin
                     s10 <= s10 + 4'd1;
                  end else begin
                     s10 <= 4'd0;
                     if (at_max) begin
                        m1   <= 4'd0;
                        m10  <= 4'd0;
                        wrap <= 1'b1;
                     end else if (m1 != 4'd9) begin
                        m1 <= m1 + 4'd1;
                     end else begin
                        m1  <= 4'd0;
                        m10 <= m10 + 4'd1;
                     end
                  end
               end
            end
            case (state)
               IDLE:    if (ss_ev) state <= RUN;
               RUN:     if (ss_ev) state <= PAUSE;
               PAUSE:   if (ss_ev) state <= RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef LAP_HOLD_EN
   logic       lap_hist, lap_ev;
   logic [3:0] cap_s1, cap_s10, cap_m1, cap_m10;

   assign lap_ev = lap & ~lap_hist;

   // The captured digits are the ones on display at the lap edge, before any coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_hist <= 1'b1;
         lap_held <= 1'b0;
         cap_s1   <= 4'd0;
         cap_s10  <= 4'd0;
         cap_m1   <= 4'd0;
         cap_m10  <= 4'd0;
      end else begin
         lap_hist <= lap;
         if (clr_ev) begin
            lap_held <= 1'b0;
         end else if (lap_ev && state != IDLE) begin
            lap_held <= ~lap_held;
            if (!lap_held) begin
               cap_s1  <= s1;
               cap_s10 <= s10;
               cap_m1  <= m1;
               cap_m10 <= m10;
            end
         end
      end
   end

   assign sec_ones = lap_held ? cap_s1  : s1;
   assign sec_tens = lap_held ? cap_s10 : s10;
   assign min_ones = lap_held ? cap_m1  : m1;
   assign min_tens = lap_held ? cap_m10 : m10;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign lap_held   = 1'b0;
   assign sec_ones   = s1;
   assign sec_tens   = s10;
   assign min_ones   = m1;
   assign min_tens   = m10;
`endif

endmodule

// File: doc/tick_bcd_stopwatch.md
Name: tick_bcd_stopwatch

Overview:
- MM:SS stopwatch in BCD. Advances one second per single-cycle enable pulse `tick`.
- `tick` comes from the upstream parameterizable frequency divider, configured for a 1 Hz pulse from the board oscillator.
- Start/stop and clear come from debounced push-buttons.
- BCD digit outputs feed the downstream 7-segment multiplexer.

Parameters:
- MAX_MINUTES, 59, last minute value before wrap. Legal range 1..99. At MAX_MINUTES:59 the next counted tick wraps to 00:00.

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle enable pulse from the frequency divider, 1 Hz in the system. Assumed never high two cycles in a row.
- start_stop  input  1  debounced level from button; only rising edges act.
- clear  input  1  debounced level from button; only rising edges act.
- lap  input  1  debounced level from button; only rising edges act. Ignored unless LAP_HOLD_EN is defined.
- sec_ones  output  4  BCD 0..9.
- sec_tens  output  4  BCD 0..5.
- min_ones  output  4  BCD 0..9.
- min_tens  output  4  BCD 0..9.
- running  output  1  1 while in state RUN.
- wrap  output  1  one-cycle pulse on wrap from MAX_MINUTES:59 to 00:00.
- lap_held  output  1  1 while the display is frozen (LAP_HOLD_EN only).

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: state IDLE, all digits 0, running=0, wrap=0, lap_held=0.
  - Reset also sets the edge-detect history registers to 1, so a button held through reset produces no event.
- Edge detection:
  - Each button input has a history flop. An event is `input & ~history`.
  - The event acts on the same clk edge at which the input is first sampled high. The digit and state change is visible one cycle after the input first reads 1.
- States and transitions:
  - IDLE: digits 00:00, not counting.
    - start_stop event -> RUN.
  - RUN: counting. running=1.
    - start_stop event -> PAUSE.
  - PAUSE: digits held.
    - start_stop event -> RUN.
  - Any state: clear event -> IDLE and digits zeroed in the same edge.
- Counting:
  - Counting happens only when the current (pre-transition) state is RUN and tick=1.
  - Carry chain: sec_ones 9->0 increments sec_tens; sec_tens 5->0 increments min_ones; min_ones 9->0 increments min_tens.
  - Wrap: at min_tens:min_ones == MAX_MINUTES and seconds 59, a tick loads 00:00 and pulses wrap for one cycle. State stays RUN.
  - Digits never leave their legal BCD ranges.
- Simultaneous events:
  - clear + start_stop: clear wins, result is IDLE.
  - clear + tick: clear wins, result is 00:00.
  - RUN with start_stop + tick: the tick is counted, then the state goes to PAUSE.
  - PAUSE or IDLE with start_stop + tick: the tick is not counted.
- Reset mid-count: returns to IDLE at 00:00 on the next edge. wrap is suppressed even if a wrap tick coincides with reset.
- Output timing: all outputs are registered (or pure state decode); there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LAP_HOLD_EN.
- Defined:
  - A lap event while in RUN or PAUSE toggles lap_held.
  - On a 0->1 toggle, the current digits are captured into a display register.
  - While lap_held=1, the output digits show the captured value and the internal count continues.
  - A second lap event releases the hold, and the outputs show live digits from the next cycle.
  - Clear or rst forces lap_held=0.
  - A lap event in IDLE is ignored.
  - lap and clear together: clear wins.
- Undefined:
  - The lap input is unused and has no history flop.
  - lap_held is tied to 0.
  - The outputs always show the live count.

Test Plan:
1. Reset/hold-through-reset: assert rst with start_stop=1 held, release rst, keep start_stop=1 for 5 cycles -> state IDLE, digits 00:00, running=0.
2. Basic count: start_stop pulse, then 75 tick pulses spaced 4 cycles apart -> 01:15, running=1. start_stop pulse -> running=0. 3 further ticks -> still 01:15.
3. Wrap: MAX_MINUTES=2, run 179 ticks -> 02:59, wrap=0. The 180th tick -> 00:00, wrap=1 for exactly one cycle, running=1.
4. Simultaneity: in RUN at 00:09, start_stop event together with tick -> 00:10 and PAUSE. Then clear event together with start_stop event and tick -> IDLE, 00:00.
5. Carry check: run to 09:59 with MAX_MINUTES=59, one tick -> min_tens=1, min_ones=0, sec_tens=0, sec_ones=0.
6. LAP_HOLD_EN defined, at 00:20 in RUN:
   - lap event -> lap_held=1.
   - 10 ticks -> outputs stay 00:20.
   - lap event -> outputs 00:30, lap_held=0.
   - Macro undefined, same stimulus -> outputs 00:30 with no freeze, lap_held stays 0.
